router_fifo: RTL and testbench
==============================

# router_fifo

Per-destination output buffer of the 1x3 router: three instances sit directly downstream of the write-enable decode and the timeout/soft-reset logic, one per output port. Each instance stores packet bytes, tagged with a header marker, in a DEPTH-entry FIFO. It reports `full`/`empty` back to the synchroniser and delivers bytes to the destination on `read_enb`. It tracks packet length from the header so that `data_out` returns to idle after the parity byte.

## Interface
- `DEPTH`, 16: number of entries; power of two, at least 4.
- `WIDTH`, 8: data byte width.
- `clock`  in  1  single clock; all state is updated on the rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `soft_reset`  in  1  synchronous flush from the timeout logic, active-high.
- `write_enb`  in  1  write request, one bit of the decoded 3-bit write enable.
- `lfd_state`  in  1  marks the current `data_in` byte as a packet header.
- `data_in`  in  WIDTH  byte to store.
- `read_enb`  in  1  read request from the destination.
- `data_out`  out  WIDTH  registered read data.
- `full`  out  1  all DEPTH entries occupied.
- `empty`  out  1  no entries occupied.

## Operation
- **Storage**
  - DEPTH × (WIDTH+1) array.
  - Bit WIDTH holds the `lfd_state` tag; bits WIDTH-1:0 hold the data.
- **Pointers**
  - `wr_ptr` and `rd_ptr` are each log2(DEPTH)+1 bits wide; the MSB is the wrap bit.
  - `empty` = pointers equal.
  - `full` = low bits equal and MSBs differ.
  - Both flags are combinational from the pointer registers.
- **Write accept:** `write_enb && !full`. Store {`lfd_state`, `data_in`} at `wr_ptr`, then increment `wr_ptr`, wrapping modulo 2·DEPTH.
- **Read accept:** `read_enb && !empty`. `data_out <= mem[rd_ptr]` data bits, then increment `rd_ptr`.
- **Packet counter**
  - `pkt_cnt` is 7 bits, reset value 0.
  - On an accepted read whose tag bit is 1, load `pkt_cnt` with data[7:2] + 1 (payload length plus parity byte, range 1..64). This reload also applies if the previous packet was incomplete.
  - On an accepted read whose tag bit is 0, decrement `pkt_cnt` if it is nonzero; it saturates at 0.
- **data_out update priority**
  1. Accepted read: load the read byte.
  2. Else if `pkt_cnt == 0`: drive 8'h00.
  3. Else: hold the current value.
- **Priority at each edge:** `resetn` low > `soft_reset` > normal read/write.
- **soft_reset** takes effect at the next edge:
  - `wr_ptr`, `rd_ptr` and `pkt_cnt` go to 0; `data_out` goes to 8'h00.
  - A write or read presented in the same cycle is dropped.
  - Array contents are don't-care.
- **Simultaneous read and write:** both are accepted when the flags allow.
  - When full: the read is accepted and the write is rejected; `full` falls after the edge.
  - When empty: the write is accepted and the read is rejected; `data_out` follows rule 2 or 3 above.
- **Rejected writes** (write while full) are lost silently. Upstream must not write while `full`, because the synchroniser's `fifo_full` stalls it.

## Timing
- **Reset values:** `data_out` = 8'h00, `empty` = 1, `full` = 0, pointers = 0, `pkt_cnt` = 0.
- **resetn** acts immediately and asynchronously, without waiting for an edge. Release is synchronised externally.
- **Write to flag:** a write accepted at edge N clears `empty` after edge N.
- **Write to read data:** the earliest read of that entry is accepted at edge N+1, and `data_out` is valid after edge N+1. Read latency is one clock.
- **Header to idle:** with a header of length L read at edge H and continuous reads, the parity byte appears after edge H+L+1. `data_out` reads 8'h00 after the next edge that has no read.
- **Fill:** `full` asserts after the DEPTH-th accepted write with no intervening read.
- **Flag contract:** flags are consumed combinationally by the synchroniser in the same cycle; `vld_out` = ~`empty`.

## Structure
- **Package `router_pkg`:**
  - `DATA_W` = 8, `FIFO_DEPTH` = 16.
  - `LEN_MSB` = 7, `LEN_LSB` = 2, `ADDR_MSB` = 1 (header field positions).
  - `PKT_CNT_W` = 7.
  - Shared with the FSM and register blocks.
- **Sub-module `router_fifo_mem`:**
  - Plain (WIDTH+1) × DEPTH register array, synchronous write, asynchronous read by address.
  - Pointers, flags, the packet counter and the `data_out` register stay in `router_fifo`.

## Test plan
- **Reset:** drive `resetn` low mid-write with 5 entries stored → immediately `empty` = 1, `full` = 0, `data_out` = 8'h00.
- **Single packet:** write header 8'h0C (len 3, tagged) plus 3 payload bytes and 1 parity byte, then read 5 times back-to-back → `data_out` = 0C, p0, p1, p2, parity on consecutive cycles, 8'h00 the cycle after, `empty` = 1.
- **Fill and overflow:** 16 writes → `full` = 1 after the 16th. A 17th write with `data_in` = 8'hAA is dropped, and a subsequent drain of 16 reads never returns AA.
- **Full simultaneous read/write:** at full, assert `read_enb` and `write_enb` together → read accepted, write rejected, `full` = 0 after the edge. Also cover pointer wrap after 40 mixed operations; the data order is preserved.
- **Soft reset:** store 7 entries, assert `soft_reset` together with `write_enb` → `empty` = 1 and `data_out` = 8'h00 after the edge, and the concurrent write is absent.
- **Truncated packet:** read a header (len 10) followed by 2 bytes, then a new tagged header (len 1) → `pkt_cnt` reloads to 2, and `data_out` idles after the new packet's parity byte.

Source files
------------

// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared router constants, header field positions and helpers
// Used by router_fifo, the router FSM and the register blocks.
//   DATA_W / FIFO_DEPTH : default byte width and per-port buffer depth
//   LEN_MSB..LEN_LSB    : payload length field of a header byte
//   ADDR_MSB..0         : destination address field of a header byte
//   PKT_CNT_W           : width of the per-port packet byte counter
package router_pkg;

  localparam int DATA_W     = 8;
  localparam int FIFO_DEPTH = 16;

  localparam int LEN_MSB  = 7;
  localparam int LEN_LSB  = 2;
  localparam int ADDR_MSB = 1;

  localparam int PKT_CNT_W = 7;

  // Bytes still to deliver after a header: payload length plus the parity byte.
  function automatic logic [PKT_CNT_W-1:0] hdr_pkt_cnt(input logic [LEN_MSB-LEN_LSB:0] len);
    return PKT_CNT_W'(len) + PKT_CNT_W'(1);
  endfunction

  function automatic logic [ADDR_MSB:0] hdr_dest(input logic [DATA_W-1:0] hdr);
    return hdr[ADDR_MSB:0];
  endfunction

endpackage

// File: rtl/router_fifo_mem.sv
// rtl/router_fifo_mem.sv - tagged byte storage array for one router output port
// Ports:
//   clock   : write clock
//   wr_en   : store wr_word at wr_addr on the rising edge
//   wr_addr : write entry index
//   wr_word : {header tag, data byte}
//   rd_addr : read entry index
//   rd_word : contents of entry rd_addr (combinational)
module router_fifo_mem #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [WIDTH:0] wr_word,
  input  logic [AW-1:0] rd_addr,
  output logic [WIDTH:0] rd_word
);

  logic [WIDTH:0] mem [DEPTH];

  // No reset: contents are only ever observed through entries written since the last flush.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_word;
    end
  end

  assign rd_word = mem[rd_addr];

endmodule

// File: rtl/router_fifo.sv
// rtl/router_fifo.sv - per-destination packet buffer of the 1x3 router
// Ports:
//   clock, resetn  : clock; asynchronous active-low reset
//   soft_reset     : synchronous flush from the timeout logic
//   write_enb      : write request (one bit of the decoded write enable)
//   lfd_state      : marks data_in as a packet header
//   data_in        : byte to store
//   read_enb       : read request from the destination
//   data_out       : registered read data, 0 when idle between packets
//   full, empty    : occupancy flags, combinational from the pointers
module router_fifo
  import router_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH,
  parameter int WIDTH = DATA_W
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             soft_reset,
  input  logic             write_enb,
  input  logic             lfd_state,
  input  logic [WIDTH-1:0] data_in,
  input  logic             read_enb,
  output logic [WIDTH-1:0] data_out,
  output logic             full,
  output logic             empty
);

  localparam int AW    = $clog2(DEPTH);
  localparam int PTR_W = AW + 1;

  // Pointer MSB is a wrap bit so full and empty are distinguishable.
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [PKT_CNT_W-1:0] pkt_cnt;
  logic [WIDTH:0]       rd_word;
  logic                 wr_acc;
  logic                 rd_acc;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

  // A flush drops any concurrent write, including the array update.
  assign wr_acc = write_enb && !full && !soft_reset;
  assign rd_acc = read_enb && !empty;

  router_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH),
    .AW    (AW)
  ) u_mem (
    .clock   (clock),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr[AW-1:0]),
    .wr_word ({lfd_state, data_in}),
    .rd_addr (rd_ptr[AW-1:0]),
    .rd_word (rd_word)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      pkt_cnt  <= '0;
      data_out <= '0;
    end else if (soft_reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      pkt_cnt  <= '0;
      data_out <= '0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (rd_acc) begin
        rd_ptr   <= rd_ptr + PTR_W'(1);
        data_out <= rd_word[WIDTH-1:0];
        // A header always restarts the count, even if the previous packet was cut short.
        if (rd_word[WIDTH]) begin
          pkt_cnt <= hdr_pkt_cnt(rd_word[LEN_MSB:LEN_LSB]);
        end else if (pkt_cnt != '0) begin
          pkt_cnt <= pkt_cnt - PKT_CNT_W'(1);
        end
      end else if (pkt_cnt == '0) begin
        // Packet fully delivered: return the output to idle.
        data_out <= '0;
      end
    end
  end

endmodule

// File: tb/tb_router_fifo.sv
// tb/tb_router_fifo.sv - directed self-checking bench for router_fifo
module tb_router_fifo;

  logic       clock;
  logic       resetn;
  logic       soft_reset;
  logic       write_enb;
  logic       lfd_state;
  logic [7:0] data_in;
  logic       read_enb;
  logic [7:0] data_out;
  logic       full;
  logic       empty;

  integer errors;
  integer checks;

  router_fifo dut (
    .clock      (clock),
    .resetn     (resetn),
    .soft_reset (soft_reset),
    .write_enb  (write_enb),
    .lfd_state  (lfd_state),
    .data_in    (data_in),
    .read_enb   (read_enb),
    .data_out   (data_out),
    .full       (full),
    .empty      (empty)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // One clock with the given inputs; returns 1 time unit after the rising edge.
  task automatic cyc(input logic we, input logic lfd, input logic [7:0] din, input logic re);
    write_enb = we;
    lfd_state = lfd;
    data_in   = din;
    read_enb  = re;
    @(posedge clock);
    #1;
    write_enb = 1'b0;
    lfd_state = 1'b0;
    data_in   = 8'h00;
    read_enb  = 1'b0;
  endtask

  task automatic test_reset;
    resetn = 1'b1;
    #1 resetn = 1'b0;
    #2;
    checks++;
    if (empty !== 1'b1 || full !== 1'b0 || data_out !== 8'h00) begin
      errors++;
      $display("FAIL reset_state: empty=%b full=%b data_out=%h, need 1 0 00", empty, full, data_out);
    end
    repeat (2) @(posedge clock);
    #1 resetn = 1'b1;
    // Header len 4 plus 5 bytes, then read the header: 5 entries stay stored.
    cyc(1'b1, 1'b1, 8'h10, 1'b0);
    for (int i = 1; i <= 5; i++) cyc(1'b1, 1'b0, 8'(i), 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    checks++;
    if (data_out !== 8'h10 || empty !== 1'b0) begin
      errors++;
      $display("FAIL reset_setup: data_out=%h empty=%b, need 10 0", data_out, empty);
    end
    // Drop resetn mid-cycle while a write is presented.
    write_enb = 1'b1;
    data_in   = 8'h77;
    #3 resetn = 1'b0;
    #1;
    checks++;
    if (empty !== 1'b1 || full !== 1'b0 || data_out !== 8'h00) begin
      errors++;
      $display("FAIL reset_async: empty=%b full=%b data_out=%h, need 1 0 00", empty, full, data_out);
    end
    write_enb = 1'b0;
    data_in   = 8'h00;
    @(posedge clock);
    #1 resetn = 1'b1;
  endtask

  task automatic test_single_packet;
    logic [7:0] pkt [5];
    pkt[0] = 8'h0C; pkt[1] = 8'h11; pkt[2] = 8'h22; pkt[3] = 8'h33; pkt[4] = 8'h1E;
    cyc(1'b1, 1'b1, pkt[0], 1'b0);
    checks++;
    if (empty !== 1'b0) begin
      errors++;
      $display("FAIL write_clears_empty: empty=%b, need 0", empty);
    end
    for (int i = 1; i < 5; i++) cyc(1'b1, 1'b0, pkt[i], 1'b0);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b0, 8'h00, 1'b1);
      checks++;
      if (data_out !== pkt[i]) begin
        errors++;
        $display("FAIL single_read%0d: data_out=%h, need %h", i, data_out, pkt[i]);
      end
    end
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    checks++;
    if (data_out !== 8'h00 || empty !== 1'b1) begin
      errors++;
      $display("FAIL single_idle: data_out=%h empty=%b, need 00 1", data_out, empty);
    end
  endtask

  task automatic test_back_to_back;
    // Write and read together on an empty buffer: only the write is accepted.
    cyc(1'b1, 1'b0, 8'h55, 1'b1);
    checks++;
    if (empty !== 1'b0 || data_out !== 8'h00) begin
      errors++;
      $display("FAIL empty_rw: empty=%b data_out=%h, need 0 00", empty, data_out);
    end
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    checks++;
    if (data_out !== 8'h55 || empty !== 1'b1) begin
      errors++;
      $display("FAIL read_latency: data_out=%h empty=%b, need 55 1", data_out, empty);
    end
  endtask

  task automatic test_fill_overflow;
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, 1'b0, 8'(8'h40 + i), 1'b0);
      if (i == 14) begin
        checks++;
        if (full !== 1'b0) begin
          errors++;
          $display("FAIL fill_15: full=%b, need 0", full);
        end
      end
    end
    checks++;
    if (full !== 1'b1) begin
      errors++;
      $display("FAIL fill_16: full=%b, need 1", full);
    end
    cyc(1'b1, 1'b0, 8'hAA, 1'b0);
    checks++;
    if (full !== 1'b1) begin
      errors++;
      $display("FAIL overflow_full: full=%b, need 1", full);
    end
    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, 1'b0, 8'h00, 1'b1);
      checks++;
      if (data_out !== 8'(8'h40 + i)) begin
        errors++;
        $display("FAIL drain%0d: data_out=%h, need %h", i, data_out, 8'(8'h40 + i));
      end
    end
    checks++;
    if (empty !== 1'b1) begin
      errors++;
      $display("FAIL drain_empty: empty=%b, need 1", empty);
    end
  endtask

  task automatic test_full_rw;
    for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 8'(8'h60 + i), 1'b0);
    cyc(1'b1, 1'b0, 8'hBB, 1'b1);
    checks++;
    if (full !== 1'b0 || data_out !== 8'h60) begin
      errors++;
      $display("FAIL full_rw: full=%b data_out=%h, need 0 60", full, data_out);
    end
    for (int i = 1; i < 16; i++) begin
      cyc(1'b0, 1'b0, 8'h00, 1'b1);
      checks++;
      if (data_out !== 8'(8'h60 + i)) begin
        errors++;
        $display("FAIL full_rw_drain%0d: data_out=%h, need %h", i, data_out, 8'(8'h60 + i));
      end
    end
    checks++;
    if (empty !== 1'b1) begin
      errors++;
      $display("FAIL full_rw_write_dropped: empty=%b, need 1", empty);
    end
  endtask

  task automatic test_wrap;
    logic [7:0] q [$];
    logic [7:0] exp;
    logic       we, re, wacc, racc;
    for (int i = 0; i < 40; i++) begin
      we   = (i % 4) != 3;
      re   = (i % 3) == 0;
      wacc = we && (q.size() < 16);
      racc = re && (q.size() > 0);
      exp  = 8'h00;
      if (racc) exp = q.pop_front();
      if (wacc) q.push_back(8'(8'h80 + i));
      cyc(we, 1'b0, 8'(8'h80 + i), re);
      checks++;
      if (data_out !== exp || empty !== (q.size() == 0)) begin
        errors++;
        $display("FAIL wrap_op%0d: data_out=%h empty=%b, need %h %b", i, data_out, empty, exp, q.size() == 0);
      end
    end
    while (q.size() > 0) begin
      exp = q.pop_front();
      cyc(1'b0, 1'b0, 8'h00, 1'b1);
      checks++;
      if (data_out !== exp) begin
        errors++;
        $display("FAIL wrap_drain: data_out=%h, need %h", data_out, exp);
      end
    end
  endtask

  task automatic test_soft_reset;
    cyc(1'b1, 1'b1, 8'h20, 1'b0);
    for (int i = 0; i < 7; i++) cyc(1'b1, 1'b0, 8'(8'hC0 + i), 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    checks++;
    if (data_out !== 8'h20) begin
      errors++;
      $display("FAIL soft_setup: data_out=%h, need 20", data_out);
    end
    soft_reset = 1'b1;
    cyc(1'b1, 1'b0, 8'hCC, 1'b0);
    soft_reset = 1'b0;
    checks++;
    if (empty !== 1'b1 || full !== 1'b0 || data_out !== 8'h00) begin
      errors++;
      $display("FAIL soft_flush: empty=%b full=%b data_out=%h, need 1 0 00", empty, full, data_out);
    end
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    checks++;
    if (empty !== 1'b1 || data_out !== 8'h00) begin
      errors++;
      $display("FAIL soft_write_dropped: empty=%b data_out=%h, need 1 00", empty, data_out);
    end
  endtask

  task automatic test_truncated;
    logic [7:0] seq [6];
    logic       tag [6];
    seq[0] = 8'h28; tag[0] = 1'b1;
    seq[1] = 8'h01; tag[1] = 1'b0;
    seq[2] = 8'h02; tag[2] = 1'b0;
    seq[3] = 8'h04; tag[3] = 1'b1;
    seq[4] = 8'h0A; tag[4] = 1'b0;
    seq[5] = 8'h0B; tag[5] = 1'b0;
    for (int i = 0; i < 6; i++) cyc(1'b1, tag[i], seq[i], 1'b0);
    for (int i = 0; i < 6; i++) begin
      cyc(1'b0, 1'b0, 8'h00, 1'b1);
      checks++;
      if (data_out !== seq[i]) begin
        errors++;
        $display("FAIL trunc_read%0d: data_out=%h, need %h", i, data_out, seq[i]);
      end
      if (i == 3) begin
        checks++;
        if (dut.pkt_cnt !== 7'd2) begin
          errors++;
          $display("FAIL trunc_reload: pkt_cnt=%0d, need 2", dut.pkt_cnt);
        end
      end
    end
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    checks++;
    if (data_out !== 8'h00) begin
      errors++;
      $display("FAIL trunc_idle: data_out=%h, need 00", data_out);
    end
  endtask

  initial begin
    errors     = 0;
    checks     = 0;
    soft_reset = 1'b0;
    write_enb  = 1'b0;
    lfd_state  = 1'b0;
    data_in    = 8'h00;
    read_enb   = 1'b0;
    test_reset();
    test_single_packet();
    test_back_to_back();
    test_fill_overflow();
    test_full_rw();
    test_wrap();
    test_soft_reset();
    test_truncated();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
